// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg: shared defaults, width helper and reset constant for the sync_fifo slice.
package sync_fifo_pkg;

   localparam int unsigned DEF_DATA_W = 8;
   localparam int unsigned DEF_DEPTH  = 256;

   // Replicated across the full r_data width at reset.
   localparam logic R_DATA_RST = 1'b0;

   // Accepted-operation code, indexed as {read, write}.
   typedef enum logic [1:0] {
      OP_NONE = 2'b00,
      OP_WR   = 2'b01,
      OP_RD   = 2'b10,
      OP_BOTH = 2'b11
   } op_e;

   function automatic int unsigned cnt_width(input int unsigned depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// sync_fifo_ram: one-write/one-read storage. SYNC_FIFO_FWFT_EN selects a combinational
// read port; otherwise the read data is registered and reset.
module sync_fifo_ram
   import sync_fifo_pkg::*;
#(
   parameter int unsigned DATA_W = DEF_DATA_W,
   parameter int unsigned ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   localparam int unsigned WORDS = 1 << ADDR_W;

   logic [DATA_W-1:0] mem [WORDS];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

`ifdef SYNC_FIFO_FWFT_EN
   logic unused_fwft;
   assign unused_fwft = ^{rst_n, re};
   assign rdata       = mem[raddr];
`else
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rdata <= {DATA_W{R_DATA_RST}};
      end else if (re) begin
         rdata <= mem[raddr];
      end
   end
`endif

endmodule

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with count, almost flags and overflow/underflow pulses.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; default is registered reads.
module sync_fifo
   import sync_fifo_pkg::*;
#(
   parameter  int unsigned DATA_W   = DEF_DATA_W,
   parameter  int unsigned DEPTH    = DEF_DEPTH,
   parameter  int unsigned AF_LEVEL = DEPTH - 2,
   parameter  int unsigned AE_LEVEL = 2,
   localparam int unsigned CNT_W    = cnt_width(DEPTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              w_en,
   input  logic [DATA_W-1:0] w_data,
   input  logic              r_en,
   output logic [DATA_W-1:0] r_data,
   output logic              w_full,
   output logic              r_empty,
   output logic              almost_full,
   output logic              almost_empty,
   output logic [CNT_W-1:0]  count,
   output logic              overflow,
   output logic              underflow
);

   localparam int unsigned      ADDR_W   = CNT_W - 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] AF_CNT   = CNT_W'(AF_LEVEL);
   localparam logic [CNT_W-1:0] AE_CNT   = CNT_W'(AE_LEVEL);

   if (DATA_W < 1) begin : g_width_chk
      $error("sync_fifo: DATA_W must be at least 1");
   end
   if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
      $error("sync_fifo: DEPTH must be a power of two and at least 4");
   end
   if (!(AE_LEVEL < AF_LEVEL && AF_LEVEL <= DEPTH)) begin : g_level_chk
      $error("sync_fifo: require AE_LEVEL < AF_LEVEL <= DEPTH");
   end

   logic [CNT_W-1:0]  wr_ptr;
   logic [CNT_W-1:0]  rd_ptr;
   logic [CNT_W-1:0]  count_nxt;
   logic              wr_acc;
   logic              rd_acc;
   logic              ram_we;
   logic [DATA_W-1:0] ram_q;
   op_e               op;

   // Acceptance uses the registered flags only, so a full FIFO rejects a write even
   // when a read frees a slot in the same cycle (and likewise for reads when empty).
   assign wr_acc = w_en && !w_full;
   assign rd_acc = r_en && !r_empty;
   assign ram_we = wr_acc && rst_n;
   assign op     = op_e'({rd_acc, wr_acc});

   always_comb begin
      count_nxt = count;
      unique case (op)
         OP_WR:   count_nxt = count + CNT_W'(1);
         OP_RD:   count_nxt = count - CNT_W'(1);
         default: count_nxt = count;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         w_full       <= 1'b0;
         r_empty      <= 1'b1;
         almost_full  <= 1'b0;
         almost_empty <= 1'b1;
         overflow     <= 1'b0;
         underflow    <= 1'b0;
      end else begin
         if (wr_acc) begin
            wr_ptr <= wr_ptr + CNT_W'(1);
         end
         if (rd_acc) begin
            rd_ptr <= rd_ptr + CNT_W'(1);
         end
         count        <= count_nxt;
         w_full       <= (count_nxt == FULL_CNT);
         r_empty      <= (count_nxt == '0);
         almost_full  <= (count_nxt >= AF_CNT);
         almost_empty <= (count_nxt <= AE_CNT);
         overflow     <= w_en && w_full;
         underflow    <= r_en && r_empty;
      end
   end

   sync_fifo_ram #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (ram_we),
      .waddr (wr_ptr[ADDR_W-1:0]),
      .wdata (w_data),
      .re    (rd_acc),
      .raddr (rd_ptr[ADDR_W-1:0]),
      .rdata (ram_q)
   );

`ifdef SYNC_FIFO_FWFT_EN
   // Head word is stale while empty; present the reset value instead.
   assign r_data = r_empty ? {DATA_W{R_DATA_RST}} : ram_q;
`else
   assign r_data = ram_q;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: directed stimulus with a queue scoreboard and a per-cycle monitor.
module tb_sync_fifo;

   localparam int DATA_W   = 8;
   localparam int DEPTH    = 16;
   localparam int AF_LEVEL = 14;
   localparam int AE_LEVEL = 2;

   logic              clk;
   logic              rst_n;
   logic              w_en;
   logic [DATA_W-1:0] w_data;
   logic              r_en;
   logic [DATA_W-1:0] r_data;
   logic              w_full;
   logic              r_empty;
   logic              almost_full;
   logic              almost_empty;
   logic [4:0]        count;
   logic              overflow;
   logic              underflow;

   sync_fifo #(
      .DATA_W   (DATA_W),
      .DEPTH    (DEPTH),
      .AF_LEVEL (AF_LEVEL),
      .AE_LEVEL (AE_LEVEL)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .w_en         (w_en),
      .w_data       (w_data),
      .r_en         (r_en),
      .r_data       (r_data),
      .w_full       (w_full),
      .r_empty      (r_empty),
      .almost_full  (almost_full),
      .almost_empty (almost_empty),
      .count        (count),
      .overflow     (overflow),
      .underflow    (underflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Scoreboard: expected FIFO contents, last word read out, expected pulses.
   logic [DATA_W-1:0] data_q [$];
   logic [DATA_W-1:0] last_rdata = '0;
   logic              exp_ovf    = 1'b0;
   logic              exp_unf    = 1'b0;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   always @(posedge clk) begin
      if (!rst_n) begin
         data_q.delete();
         exp_ovf    <= 1'b0;
         exp_unf    <= 1'b0;
         last_rdata <= '0;
      end else begin
         exp_ovf <= w_en && (data_q.size() == DEPTH);
         exp_unf <= r_en && (data_q.size() == 0);
         if (w_en && r_en && data_q.size() != 0 && data_q.size() != DEPTH) begin
            last_rdata <= data_q[0];
            data_q.delete(0);
            data_q.push_back(w_data);
         end else if (w_en && data_q.size() != DEPTH) begin
            data_q.push_back(w_data);
         end else if (r_en && data_q.size() != 0) begin
            last_rdata <= data_q[0];
            data_q.delete(0);
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic monitor_cycle();
      int sz;
      sz = data_q.size();
      check("count", 32'(count), 32'(sz));
      check("flags{full,empty,af,ae,ovf,unf}",
            32'({w_full, r_empty, almost_full, almost_empty, overflow, underflow}),
            32'({sz == DEPTH, sz == 0, sz >= AF_LEVEL, sz <= AE_LEVEL, exp_ovf, exp_unf}));
`ifdef SYNC_FIFO_FWFT_EN
      if (sz != 0) begin
         check("r_data_head", 32'(r_data), 32'(data_q[0]));
      end
`else
      check("r_data_held", 32'(r_data), 32'(last_rdata));
`endif
   endtask

   task automatic cyc(input logic w, input logic [DATA_W-1:0] d, input logic r);
      w_en   = w;
      w_data = d;
      r_en   = r;
      @(negedge clk);
   endtask

   int unsigned max_cnt;

   initial begin
      rst_n  = 1'b0;
      w_en   = 1'b0;
      w_data = '0;
      r_en   = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      fork
         forever begin
            @(negedge clk);
            monitor_cycle();
         end
         begin
            #200000;
            $display("FAIL watchdog: simulation time limit reached");
            $fatal(1, "watchdog");
         end
      join_none

      // Reset state after idle
      repeat (5) cyc(1'b0, '0, 1'b0);
      check("rst_empty", 32'(r_empty), 32'd1);
      check("rst_almost_empty", 32'(almost_empty), 32'd1);
      check("rst_count", 32'(count), 32'd0);
      check("rst_others", 32'({w_full, almost_full, overflow, underflow}), 32'd0);
      check("rst_r_data", 32'(r_data), 32'd0);

      // Fill 0..15
      for (int i = 0; i < DEPTH; i++) begin
         cyc(1'b1, 8'(i), 1'b0);
         check("fill_almost_full", 32'(almost_full), 32'((i + 1) >= 14));
      end
      check("full_count", 32'(count), 32'd16);
      check("full_flag", 32'(w_full), 32'd1);
      cyc(1'b1, 8'hEE, 1'b0);
      check("ovf_pulse", 32'(overflow), 32'd1);
      check("ovf_count", 32'(count), 32'd16);
      cyc(1'b0, '0, 1'b0);
      check("ovf_one_cycle", 32'(overflow), 32'd0);

      // Drain 16, then read on empty
      for (int i = 0; i < DEPTH; i++) cyc(1'b0, '0, 1'b1);
`ifndef SYNC_FIFO_FWFT_EN
      check("drain_last_word", 32'(r_data), 32'd15);
`endif
      check("drain_empty", 32'(r_empty), 32'd1);
      cyc(1'b0, '0, 1'b1);
      check("unf_pulse", 32'(underflow), 32'd1);
      check("unf_count", 32'(count), 32'd0);
      cyc(1'b0, '0, 1'b0);
      check("unf_one_cycle", 32'(underflow), 32'd0);

      // Streaming 40 words through pointer wrap, reads start 3 cycles late
      max_cnt = 0;
      for (int t = 0; t < 43; t++) begin
         cyc(t < 40, 8'(t), t >= 3);
         if (32'(count) > max_cnt) max_cnt = 32'(count);
      end
      check("stream_max_count_le4", 32'(max_cnt <= 4), 32'd1);
      check("stream_end_count", 32'(count), 32'd0);
`ifndef SYNC_FIFO_FWFT_EN
      check("stream_last_word", 32'(r_data), 32'd39);
`endif

      // Simultaneous read/write at full
      for (int i = 0; i < DEPTH; i++) cyc(1'b1, 8'(100 + i), 1'b0);
      check("full2_flag", 32'(w_full), 32'd1);
`ifdef SYNC_FIFO_FWFT_EN
      check("full2_head", 32'(r_data), 32'd100);
`endif
      cyc(1'b1, 8'd200, 1'b1);
      check("full_both_ovf", 32'(overflow), 32'd1);
      check("full_both_count", 32'(count), 32'd15);
`ifndef SYNC_FIFO_FWFT_EN
      check("full_both_word", 32'(r_data), 32'd100);
`endif
      for (int i = 0; i < DEPTH - 1; i++) cyc(1'b0, '0, 1'b1);

      // Simultaneous read/write at empty
      cyc(1'b1, 8'h3C, 1'b1);
      check("empty_both_unf", 32'(underflow), 32'd1);
      check("empty_both_count", 32'(count), 32'd1);
      cyc(1'b0, '0, 1'b1);
      check("empty_both_drain", 32'(count), 32'd0);
`ifndef SYNC_FIFO_FWFT_EN
      check("empty_both_word", 32'(r_data), 32'h3C);
`endif

      // Reset mid-operation with a write in flight
      for (int i = 0; i < 10; i++) cyc(1'b1, 8'(50 + i), 1'b0);
      check("pre_rst_count", 32'(count), 32'd10);
      rst_n = 1'b0;
      cyc(1'b1, 8'h77, 1'b0);
      rst_n = 1'b1;
      check("midrst_count", 32'(count), 32'd0);
      check("midrst_empty", 32'(r_empty), 32'd1);
      check("midrst_no_ovf", 32'(overflow), 32'd0);
      cyc(1'b1, 8'hA5, 1'b0);
`ifdef SYNC_FIFO_FWFT_EN
      check("a5_head", 32'(r_data), 32'hA5);
`endif
      cyc(1'b0, '0, 1'b1);
`ifndef SYNC_FIFO_FWFT_EN
      check("a5_read", 32'(r_data), 32'hA5);
`endif
      check("a5_count", 32'(count), 32'd0);
      cyc(1'b0, '0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/sync_fifo.md
# sync_fifo

Parametrised single-clock FIFO: the next generation of the team's 8-bit dual-clock FIFO, generalised in data width and depth, with programmable almost-full/almost-empty flags, an occupancy count and sticky-free overflow/underflow pulses. Sits between same-clock producer/consumer blocks (UART/bus bridges, packet buffers) where clock-domain crossing is not needed. Optional first-word-fall-through read mode is selected at compile time.

## Interface
- DATA_W, 8, data width in bits (≥1)
- DEPTH, 256, number of entries; power of two, ≥4
- AF_LEVEL, DEPTH-2, almost_full asserts when count ≥ AF_LEVEL
- AE_LEVEL, 2, almost_empty asserts when count ≤ AE_LEVEL
- CNT_W, $clog2(DEPTH)+1, derived, not overridden

- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  synchronous active-low reset, sampled on rising edge of clk
- w_en  in  1  write request
- w_data  in  DATA_W  write data, captured with accepted write
- r_en  in  1  read request
- r_data  out  DATA_W  read data
- w_full  out  1  FIFO full (count == DEPTH)
- r_empty  out  1  FIFO empty (count == 0)
- almost_full  out  1  count ≥ AF_LEVEL
- almost_empty  out  1  count ≤ AE_LEVEL
- count  out  CNT_W  current occupancy, 0..DEPTH
- overflow  out  1  one-cycle pulse: write rejected
- underflow  out  1  one-cycle pulse: read rejected

## Operation
- Write accepted when w_en && !w_full; data stored at wr_ptr, wr_ptr increments.
- Read accepted when r_en && !r_empty; rd_ptr increments.
- Pointers are CNT_W bits (extra wrap bit); address = low $clog2(DEPTH) bits; wrap from DEPTH-1 to 0 is natural rollover.
- count: +1 on write-only, −1 on read-only, unchanged on both or neither.
- Full with w_en && r_en: read accepted, write rejected (flags are registered, not look-ahead); overflow pulses.
- Empty with w_en && r_en: write accepted, read rejected; underflow pulses.
- overflow/underflow assert the cycle after the rejected request, for one cycle per rejected request.
- All flags derived from registered count; no combinational path from w_en/r_en to any flag.
- Memory contents are not reset; only pointers, count, flags, r_data.

## Timing
- Reset values: r_data=0, w_full=0, r_empty=1, almost_full=0, almost_empty=1, count=0, overflow=0, underflow=0.
- Reset mid-operation: cycle after rst_n sampled low, FIFO is empty; in-flight requests in that cycle are discarded, no overflow/underflow pulses.
- count, w_full, r_empty, almost_* update the cycle after the accepted operation.
- Write into empty FIFO: r_empty deasserts next cycle.
- Standard mode: r_data registered, valid one cycle after the accepted read, held until next accepted read.
- Back-to-back: one write and one read per cycle sustained indefinitely.

## Configuration
- Macro SYNC_FIFO_FWFT_EN.
- Defined: first-word-fall-through; r_data shows the head entry whenever r_empty=0 (zero read latency); r_en acts as pop/acknowledge; r_data is don't-care while empty.
- Undefined: standard mode as above; r_data only changes after an accepted read.
- Flags, count and overflow/underflow behaviour identical in both modes.

## Structure
- Shared package sync_fifo_pkg: default DATA_W/DEPTH, CNT_W derivation function (clog2+1), reset value constant for r_data.
- One sub-module: sync_fifo_ram, simple dual-port memory (one write port, one read port, combinational read address for FWFT, registered read otherwise); top holds pointers, count, flags.
- Parameter check at elaboration: DEPTH power of two, AE_LEVEL < AF_LEVEL ≤ DEPTH.

## Test plan
Bench config DATA_W=8, DEPTH=16, AF_LEVEL=14, AE_LEVEL=2; both macro settings.
- Reset, then idle 5 cycles -> r_empty=1, almost_empty=1, count=0, all others 0.
- Write 0..15 consecutively -> count=16, w_full=1, almost_full from count=14; 17th write -> overflow one-cycle pulse, count stays 16.
- Read 16 words -> data 0..15 in order (standard: one cycle after each r_en; FWFT: on r_data before pop); then r_en on empty -> underflow pulse, count 0.
- Write 40 words while reading continuously, starting read 3 cycles after writes -> ordered data 0..39 through pointer wrap, count never exceeds 4.
- At full, w_en=1 and r_en=1 same cycle -> head word read, write rejected, overflow=1, count=15; at empty both asserted -> write accepted, underflow=1, count=1.
- Fill to 10, assert rst_n=0 one cycle with w_en=1 -> count=0, r_empty=1, no overflow; subsequent write/read of 0xA5 returns 0xA5.
